// File: rtl/multicycle_control.sv
// multicycle_control: FSM controller for a multicycle datapath.
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH, with a retired-instruction counter.
// The opcode and func fields are captured on leaving DECODE. EXEC, MEM and WB
// decode only those captured copies, so later changes on opCode/func do not
// disturb the datapath controls.
// Optional feature macro: MULTICYCLE_ILLEGAL_TRAP_EN. When it is defined, an
// illegal instruction parks the FSM in TRAP until reset. When it is undefined,
// an illegal instruction is handled as a NOP and illegal pulses for one cycle.
module multicycle_control #(
  parameter int OPW  = 4,
  parameter int FW   = 3,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OPW-1:0]  opCode,
  input  logic [FW-1:0]   func,
  input  logic            mem_ready,
  input  logic            zero,
  output logic            PCWrite,
  output logic            IRWrite,
  output logic            RegDst,
  output logic            ALUSrc,
  output logic            MemtoReg,
  output logic            RegWrt,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            Branch,
  output logic [2:0]      ALUCtrl,
  output logic [2:0]      state,
  output logic            illegal,
  output logic [CNTW-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [2:0]      fn_q, fn_d;
  logic [CNTW-1:0] instret_q, instret_d;

  // Nonzero bits above the architected opcode/func fields make the instruction illegal.
  logic op_hi, fn_hi;
  generate
    if (OPW > 4) begin : g_op_hi
      assign op_hi = |opCode[OPW-1:4];
    end else begin : g_op_nohi
      assign op_hi = 1'b0;
    end
    if (FW > 3) begin : g_fn_hi
      assign fn_hi = |func[FW-1:3];
    end else begin : g_fn_nohi
      assign fn_hi = 1'b0;
    end
  endgenerate

  // Legality of the instruction currently presented to DECODE.
  logic dec_illegal;
  always_comb begin
    dec_illegal = op_hi || (opCode[3:0] > 4'd8) ||
                  ((opCode[3:0] == 4'd0) && (fn_hi || (func[2:0] > 3'd5)));
  end

  // Instruction classes, taken from the captured opcode.
  logic is_r, is_imm, is_lw, is_sw, is_beq, is_bne;
  always_comb begin
    is_r   = (op_q == 4'd0);
    is_imm = (op_q >= 4'd1) && (op_q <= 4'd4);
    is_lw  = (op_q == 4'd5);
    is_sw  = (op_q == 4'd6);
    is_beq = (op_q == 4'd7);
    is_bne = (op_q == 4'd8);
  end

  // Next-state, field-capture and retire-counter logic.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    fn_d      = fn_q;
    instret_d = instret_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        op_d = opCode[3:0];
        fn_d = func[2:0];
        if (dec_illegal) begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          state_d = S_FETCH;
`endif
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_beq || is_bne) begin
          state_d   = S_FETCH;
          instret_d = instret_q + CNTW'(1);
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (is_lw) begin
            state_d = S_WB;
          end else begin
            state_d   = S_FETCH;
            instret_d = instret_q + CNTW'(1);
          end
        end
      end
      S_WB: begin
        state_d   = S_FETCH;
        instret_d = instret_q + CNTW'(1);
      end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      S_TRAP:   state_d = S_TRAP;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  // State, captured fields and counter; rst_n clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      op_q      <= 4'd0;
      fn_q      <= 3'd0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      fn_q      <= fn_d;
      instret_q <= instret_d;
    end
  end

  // Datapath controls, decoded from the state and the captured fields.
  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    RegWrt   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Branch   = 1'b0;
    ALUCtrl  = 3'b000;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_EXEC: begin
        ALUSrc = is_imm || is_lw || is_sw;
        case (op_q)
          4'd0:          ALUCtrl = fn_q;
          4'd2:          ALUCtrl = 3'b010;
          4'd3:          ALUCtrl = 3'b011;
          4'd4:          ALUCtrl = 3'b100;
          4'd7, 4'd8:    ALUCtrl = 3'b001;
          default:       ALUCtrl = 3'b000;
        endcase
        if (is_beq || is_bne) begin
          Branch  = 1'b1;
          PCWrite = is_beq ? zero : ~zero;
        end
      end
      S_MEM: begin
        MemRead  = is_lw;
        MemWrite = is_sw;
      end
      S_WB: begin
        RegWrt   = 1'b1;
        RegDst   = is_r;
        MemtoReg = is_lw;
      end
      default: ;
    endcase
  end

  assign state   = state_q;
  assign instret = instret_q;
  assign illegal = ((state_q == S_DECODE) && dec_illegal) || (state_q == S_TRAP);

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. It runs with CNTW=2 so that the
// retire counter wraps within a short instruction stream. For each instruction,
// one expected record per clock cycle is queued. The driver pops each record,
// drives its inputs and compares the DUT against it.
module tb_multicycle_control;

  localparam int CNTW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [3:0]      opCode = 4'd0;
  logic [2:0]      func = 3'd0;
  logic            mem_ready = 1'b0;
  logic            zero = 1'b0;
  logic            PCWrite, IRWrite, RegDst, ALUSrc, MemtoReg, RegWrt;
  logic            MemRead, MemWrite, Branch;
  logic [2:0]      ALUCtrl;
  logic [2:0]      state;
  logic            illegal;
  logic [CNTW-1:0] instret;

  multicycle_control #(.OPW(4), .FW(3), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .opCode(opCode), .func(func),
    .mem_ready(mem_ready), .zero(zero),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegDst(RegDst), .ALUSrc(ALUSrc),
    .MemtoReg(MemtoReg), .RegWrt(RegWrt), .MemRead(MemRead), .MemWrite(MemWrite),
    .Branch(Branch), .ALUCtrl(ALUCtrl), .state(state), .illegal(illegal),
    .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]      op;
    logic [2:0]      fn;
    logic            mr;
    logic            zr;
    logic [2:0]      st;
    logic [11:0]     ctl;
    logic            ill;
    logic [CNTW-1:0] cnt;
  } item_t;

  item_t           exp_q[$];
  logic [CNTW-1:0] cnt = '0;
  int              n_checks = 0;
  int              n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  // Control vector layout: PCWrite IRWrite RegDst ALUSrc MemtoReg RegWrt MemRead MemWrite Branch ALUCtrl[2:0]
  function automatic logic [11:0] ctl(input logic pcw, irw, rd, as, m2r, rw, mr, mw, br,
                                      input logic [2:0] alu);
    return {pcw, irw, rd, as, m2r, rw, mr, mw, br, alu};
  endfunction

  task automatic push(input logic [3:0] op, input logic [2:0] fn, input logic mr, input logic zr,
                      input logic [2:0] st, input logic [11:0] c, input logic ill);
    item_t it;
    it.op = op; it.fn = fn; it.mr = mr; it.zr = zr;
    it.st = st; it.ctl = c; it.ill = ill; it.cnt = cnt;
    exp_q.push_back(it);
  endtask

  task automatic run_queue();
    item_t it;
    while (exp_q.size() > 0) begin
      it = exp_q.pop_front();
      @(negedge clk);
      opCode = it.op; func = it.fn; mem_ready = it.mr; zero = it.zr;
      #1;
      check("state", {29'd0, state}, {29'd0, it.st});
      check("ctl", {20'd0, PCWrite, IRWrite, RegDst, ALUSrc, MemtoReg, RegWrt,
                    MemRead, MemWrite, Branch, ALUCtrl}, {20'd0, it.ctl});
      check("illegal", {31'd0, illegal}, {31'd0, it.ill});
      check("instret", 32'(instret), 32'(it.cnt));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_instret", 32'(instret), 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = '0;
  endtask

  // Queue the expected cycle-by-cycle behaviour of one instruction, then run it.
  // fw/mw: number of mem_ready=0 cycles in FETCH/MEM. abort: stop inside the MEM wait.
  task automatic exec_instr(input logic [3:0] op, input logic [2:0] fn, input int fw,
                            input int mw, input logic zr, input logic abort);
    logic       ill, br, pcw, as;
    logic [2:0] alu;
    logic [3:0] garb;
    ill  = (op > 4'd8) || ((op == 4'd0) && (fn > 3'd5));
    garb = 4'hF;
    for (int i = 0; i < fw; i++)
      push(op, fn, 1'b0, 1'($urandom_range(0, 1)), 3'd0,
           ctl(0, 0, 0, 0, 0, 0, 1, 0, 0, 3'd0), 1'b0);
    push(op, fn, 1'b1, 1'($urandom_range(0, 1)), 3'd0, ctl(1, 1, 0, 0, 0, 0, 1, 0, 0, 3'd0), 1'b0);
    push(op, fn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'd1, 12'd0, ill);
    if (ill) begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      repeat (3) push(garb, 3'd7, 1'($urandom_range(0, 1)), 1'b1, 3'd5, 12'd0, 1'b1);
`endif
    end else begin
      case (op)
        4'd0:       alu = fn;
        4'd2:       alu = 3'b010;
        4'd3:       alu = 3'b011;
        4'd4:       alu = 3'b100;
        4'd7, 4'd8: alu = 3'b001;
        default:    alu = 3'b000;
      endcase
      as  = (op >= 4'd1) && (op <= 4'd6);
      br  = (op == 4'd7) || (op == 4'd8);
      pcw = br && ((op == 4'd7) ? zr : !zr);
      push(garb, 3'd7, 1'($urandom_range(0, 1)), zr, 3'd2, ctl(pcw, 0, 0, as, 0, 0, 0, 0, br, alu), 1'b0);
      if (br) cnt = cnt + 1'b1;
      if (op == 4'd5 || op == 4'd6) begin
        for (int i = 0; i < mw; i++)
          push(garb, 3'd7, 1'b0, 1'b1, 3'd3, ctl(0, 0, 0, 0, 0, 0, op == 4'd5, op == 4'd6, 0, 3'd0), 1'b0);
        if (!abort) begin
          push(garb, 3'd7, 1'b1, 1'b1, 3'd3, ctl(0, 0, 0, 0, 0, 0, op == 4'd5, op == 4'd6, 0, 3'd0), 1'b0);
          if (op == 4'd6) cnt = cnt + 1'b1;
        end
      end
      if (!br && op != 4'd6) begin
        push(garb, 3'd7, 1'($urandom_range(0, 1)), 1'b0, 3'd4,
             ctl(0, 0, op == 4'd0, 0, op == 4'd5, 1, 0, 0, 0, 3'd0), 1'b0);
        cnt = cnt + 1'b1;
      end
    end
    run_queue();
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    if (ill) do_reset();
`endif
  endtask

  initial begin
    do_reset();
    exec_instr(4'd0, 3'd1, 0, 0, 1'b0, 1'b0);  // R sub
    exec_instr(4'd5, 3'd0, 0, 2, 1'b0, 1'b0);  // lw, 2 wait cycles in MEM
    exec_instr(4'd8, 3'd0, 0, 0, 1'b0, 1'b0);  // bne taken
    exec_instr(4'd8, 3'd0, 0, 0, 1'b1, 1'b0);  // bne not taken, counter wraps
    exec_instr(4'd1, 3'd0, 0, 0, 1'b0, 1'b0);  // addi
    exec_instr(4'd6, 3'd0, 2, 1, 1'b0, 1'b0);  // sw with FETCH and MEM waits
    exec_instr(4'd0, 3'd6, 0, 0, 1'b0, 1'b0);  // illegal func
    exec_instr(4'd15, 3'd0, 0, 0, 1'b0, 1'b0); // illegal opcode
    exec_instr(4'd2, 3'd0, 0, 0, 1'b0, 1'b0);  // andi
    exec_instr(4'd3, 3'd0, 1, 0, 1'b0, 1'b0);  // ori
    exec_instr(4'd4, 3'd0, 0, 0, 1'b0, 1'b0);  // slti
    exec_instr(4'd7, 3'd0, 0, 0, 1'b1, 1'b0);  // beq taken
    exec_instr(4'd7, 3'd0, 0, 0, 1'b0, 1'b0);  // beq not taken
    for (int f = 0; f < 6; f++)
      exec_instr(4'd0, 3'(f), 0, 0, 1'b0, 1'b0);  // every R-type func
    exec_instr(4'd0, 3'd7, 0, 0, 1'b0, 1'b0);  // illegal func 111
    exec_instr(4'd9, 3'd0, 0, 0, 1'b0, 1'b0);  // illegal opcode 1001
    exec_instr(4'd1, 3'd0, 0, 0, 1'b0, 1'b0);  // addi, counter nonzero before abort
    // Drop rst_n mid-cycle while sw waits in MEM.
    exec_instr(4'd6, 3'd0, 0, 2, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("abort_state", {29'd0, state}, 32'd0);
    check("abort_instret", 32'(instret), 32'd0);
    check("abort_memwrite", {31'd0, MemWrite}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = '0;
    exec_instr(4'd0, 3'd0, 0, 0, 1'b0, 1'b0);  // recovery: R add
    exec_instr(4'd5, 3'd0, 1, 0, 1'b0, 1'b0);  // lw zero-wait MEM
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter OPW, default 4, opcode width (SHALL be >= 4; opcode bits above [3:0] nonzero = illegal).
REQ-002 Parameter FW, default 3, func width (SHALL be >= 3; func bits above [2:0] nonzero = illegal R-type).
REQ-003 Parameter CNTW, default 16, retired-instruction counter width.
REQ-004 clk  in  1  single clock, all state changes on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 opCode  in  OPW  opcode from instruction register.
REQ-007 func  in  FW  R-type function field.
REQ-008 mem_ready  in  1  memory handshake; access completes in the cycle it is high.
REQ-009 zero  in  1  ALU zero flag, valid in EXEC.
REQ-010 PCWrite, IRWrite, RegDst, ALUSrc, MemtoReg, RegWrt, MemRead, MemWrite, Branch  out  1 each  datapath controls.
REQ-011 ALUCtrl  out  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 100 slt, 101 nor.
REQ-012 state  out  3  current state: 000 FETCH, 001 DECODE, 010 EXEC, 011 MEM, 100 WB, 101 TRAP.
REQ-013 illegal  out  1  illegal instruction detected.
REQ-014 instret  out  CNTW  retired-instruction count.

Function
REQ-015 Opcode map: 0000 R-type, 0001 addi, 0010 andi, 0011 ori, 0100 slti, 0101 lw, 0110 sw, 0111 beq, 1000 bne; all others illegal.
REQ-016 R-type func 000..101 SHALL map directly to ALUCtrl 000..101; 110/111 illegal.
REQ-017 FETCH: MemRead=1, IRWrite=mem_ready, PCWrite=mem_ready, ALUCtrl=000; stays in FETCH while mem_ready=0, else -> DECODE.
REQ-018 DECODE: opCode/func captured into internal registers; all later states decode only captured values; -> EXEC, or illegal handling per REQ-030/031.
REQ-019 EXEC: ALUSrc=1 for addi/andi/ori/slti/lw/sw; ALUCtrl per REQ-016, addi/lw/sw=000, andi=010, ori=011, slti=100, beq/bne=001.
REQ-020 EXEC for beq/bne: Branch=1, PCWrite=zero (beq) or ~zero (bne); -> FETCH (3-cycle instruction with zero-wait memory).
REQ-021 EXEC for R-type/immediate -> WB; lw/sw -> MEM.
REQ-022 MEM: lw MemRead=1, sw MemWrite=1; hold until mem_ready=1; lw -> WB, sw -> FETCH.
REQ-023 WB: RegWrt=1; RegDst=1 only for R-type; MemtoReg=1 only for lw; -> FETCH.
REQ-024 Outputs not listed for a state SHALL be 0; outputs decode from registered state and captured fields only (Moore, glitch-free w.r.t. opCode changes after DECODE).
REQ-025 Zero-wait latencies: R/imm 4, lw 5, sw 4, branch 3 cycles; each mem_ready=0 cycle in FETCH/MEM adds one.
REQ-026 instret SHALL increment by 1 on the final cycle of each legal instruction (WB, sw MEM completion, branch EXEC) and wrap modulo 2^CNTW.
REQ-027 mem_ready is ignored in DECODE, EXEC and WB.

Reset
REQ-028 rst_n low SHALL immediately force state=FETCH, instret=0, illegal=0, captured fields=0, independent of clk.
REQ-029 Reset asserted mid-instruction (any state, including a MEM wait) SHALL abort it without incrementing instret; first edge after release begins FETCH.

Configuration
REQ-030 With MULTICYCLE_ILLEGAL_TRAP_EN defined: illegal instruction in DECODE -> TRAP; TRAP holds all controls 0, illegal=1, leaves only by reset.
REQ-031 Without MULTICYCLE_ILLEGAL_TRAP_EN: illegal instruction treated as NOP: DECODE -> FETCH, illegal pulses 1 for that DECODE cycle only, instret not incremented, TRAP unreachable.

Verification
REQ-032 Reset, mem_ready=1, opCode=0000 func=001 -> states FETCH,DECODE,EXEC(ALUCtrl=001),WB(RegWrt=1,RegDst=1); instret=1.
REQ-033 opCode=0101 with mem_ready low 2 cycles in MEM -> MemRead held 3 MEM cycles, then WB MemtoReg=1; 7 cycles total.
REQ-034 opCode=1000, zero=0 -> EXEC Branch=1 PCWrite=1; same with zero=1 -> PCWrite=0; both retire.
REQ-035 opCode=1111 -> with macro: TRAP, illegal=1 stuck until rst_n=0; without: illegal 1-cycle pulse, back to FETCH, instret unchanged.
REQ-036 rst_n dropped mid-clock during sw MEM wait -> state=000, instret=0 before next edge, MemWrite=0.
REQ-037 CNTW=2, five legal instructions -> instret 1,2,3,0,1.
